// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, bus-size helper and the master bridge FSM state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_AR   = 3'd4,
        ST_R    = 3'd5
    } axi_mst_state_t;

    // AxSIZE encoding for a full-width beat: log2 of the bus width in bytes.
    function automatic logic [2:0] size_from_width(input int data_width);
        logic [2:0] size;
        size = '0;
        for (int i = 0; i < 8; i++) begin
            if ((8 << i) == data_width) size = 3'(i);
        end
        return size;
    endfunction

endpackage

// File: rtl/axi_if.sv
// AXI4 bus bundle without ID return fields; the master drives through modport m.
interface axi_if #(
    parameter int ID_W_WIDTH = 4,
    parameter int ID_R_WIDTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ID_W_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_R_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport m (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport s (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_master_bridge.sv
// Core burst request port to AXI4 master: one transaction in flight, data streams
// pass straight through, and each transaction ends with a single done pulse.
module axi_master_bridge
    import axi_pkg::*;
#(
    parameter int ID_W_WIDTH = 4,
    parameter int ID_R_WIDTH = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    localparam int ID_WIDTH  = (ID_W_WIDTH > ID_R_WIDTH) ? ID_W_WIDTH : ID_R_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ID_WIDTH-1:0]     req_id,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [7:0]              req_len,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,
    output logic                    done,
    output logic [1:0]              done_resp,
    axi_if.m                        axi_m
);

    localparam logic [2:0] BEAT_SIZE = size_from_width(DATA_WIDTH);

    axi_mst_state_t          state;
    logic [ID_WIDTH-1:0]     id_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [7:0]              beat_cnt;
    logic [1:0]              acc_resp;
    logic                    done_q;
    logic [1:0]              done_resp_q;
    logic                    beat_last;
    logic                    w_hs;
    logic                    r_hs;
    logic [1:0]              next_acc;

    assign beat_last = (beat_cnt == len_q);
    assign w_hs      = (state == ST_W) && wr_valid && axi_m.wready;
    assign r_hs      = (state == ST_R) && axi_m.rvalid && rd_ready;
    assign next_acc  = (axi_m.rresp > acc_resp) ? axi_m.rresp : acc_resp;
    assign done      = done_q;
    assign done_resp = done_resp_q;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        req_ready     = 1'b0;
        wr_ready      = 1'b0;
        rd_valid      = 1'b0;
        rd_data       = '0;
        rd_last       = 1'b0;
        axi_m.awid    = '0;
        axi_m.awaddr  = '0;
        axi_m.awlen   = '0;
        axi_m.awsize  = '0;
        axi_m.awburst = '0;
        axi_m.awvalid = 1'b0;
        axi_m.wdata   = '0;
        axi_m.wstrb   = '0;
        axi_m.wlast   = 1'b0;
        axi_m.wvalid  = 1'b0;
        axi_m.bready  = 1'b0;
        axi_m.arid    = '0;
        axi_m.araddr  = '0;
        axi_m.arlen   = '0;
        axi_m.arsize  = '0;
        axi_m.arburst = '0;
        axi_m.arvalid = 1'b0;
        axi_m.rready  = 1'b0;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_AW: begin
                axi_m.awvalid = 1'b1;
                axi_m.awid    = id_q[ID_W_WIDTH-1:0];
                axi_m.awaddr  = addr_q;
                axi_m.awlen   = len_q;
                axi_m.awsize  = BEAT_SIZE;
                axi_m.awburst = BURST_INCR;
            end
            ST_W: begin
                axi_m.wvalid = wr_valid;
                axi_m.wdata  = wr_data;
                axi_m.wstrb  = wr_strb;
                axi_m.wlast  = beat_last;
                wr_ready     = axi_m.wready;
            end
            ST_B: axi_m.bready = 1'b1;
            ST_AR: begin
                axi_m.arvalid = 1'b1;
                axi_m.arid    = id_q[ID_R_WIDTH-1:0];
                axi_m.araddr  = addr_q;
                axi_m.arlen   = len_q;
                axi_m.arsize  = BEAT_SIZE;
                axi_m.arburst = BURST_INCR;
            end
            ST_R: begin
                rd_valid     = axi_m.rvalid;
                rd_data      = axi_m.rdata;
                rd_last      = axi_m.rlast;
                axi_m.rready = rd_ready;
            end
            default: ;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            beat_cnt    <= '0;
            acc_resp    <= '0;
            done_q      <= 1'b0;
            done_resp_q <= '0;
        end else begin
            done_q      <= 1'b0;
            done_resp_q <= '0;
            case (state)
                ST_IDLE: if (req_valid) begin
                    id_q   <= req_id;
                    addr_q <= req_addr;
                    len_q  <= req_len;
                    state  <= req_write ? ST_AW : ST_AR;
                end
                ST_AW: if (axi_m.awready) begin
                    beat_cnt <= '0;
                    state    <= ST_W;
                end
                ST_W: if (w_hs) begin
                    beat_cnt <= beat_cnt + 8'd1;
                    if (beat_last) state <= ST_B;
                end
                ST_B: if (axi_m.bvalid) begin
                    done_q      <= 1'b1;
                    done_resp_q <= axi_m.bresp;
                    state       <= ST_IDLE;
                end
                ST_AR: if (axi_m.arready) begin
                    acc_resp <= RESP_OKAY;
                    state    <= ST_R;
                end
                ST_R: if (r_hs) begin
                    acc_resp <= next_acc;
                    // Termination follows RLAST alone; the beat count is not cross-checked.
                    if (axi_m.rlast) begin
                        done_q      <= 1'b1;
                        done_resp_q <= next_acc;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master_bridge.sv
// Bench for axi_master_bridge: table of transactions against a behavioural AXI RAM
// slave, with queued expectations for write beats and read beats.
module tb_axi_master_bridge;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_id;
    logic [15:0] req_addr;
    logic [7:0]  req_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done;
    logic [1:0]  done_resp;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        last;
        logic [3:0]  strb;
        logic [31:0] data;
    } wexp_t;

    typedef struct {
        logic             wr;
        logic [3:0]       id;
        logic [15:0]      addr;
        logic [7:0]       len;
        logic [3:0][31:0] data;      // write data, or expected read data
        logic [3:0][3:0]  strb;
        int               aw_delay;
        logic             bp;
        logic [1:0]       bresp;
        int               err_beat;
        logic [1:0]       exp_resp;
    } vec_t;

    wexp_t       wq[$];
    logic [32:0] rq[$];

    int          cfg_aw_delay = 0;
    logic [1:0]  cfg_bresp    = 2'b00;
    int          cfg_err_beat = -1;

    logic [3:0]  cap_id;
    logic [15:0] cap_addr;
    logic [7:0]  cap_len;
    logic [2:0]  cap_size;
    logic [1:0]  cap_burst;

    always #5 clk = ~clk;

    axi_if #(.ID_W_WIDTH(4), .ID_R_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32)) axi ();

    axi_master_bridge #(
        .ID_W_WIDTH(4), .ID_R_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_id(req_id), .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp),
        .axi_m(axi)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural AXI RAM slave, word-addressed, strobe-masked writes.
    logic [31:0] mem [0:1023];
    bit          mem_init_done;
    int          s_st, s_wait, r_beat;
    logic [9:0]  w_idx, r_idx;

    always @(posedge clk or posedge rst) begin : slave
        int    nb;
        wexp_t e;
        if (rst) begin
            if (!mem_init_done) begin
                for (int i = 0; i < 1024; i++) mem[i] <= '0;
                mem_init_done <= 1'b1;
            end
            axi.awready <= 0; axi.arready <= 0; axi.wready <= 0;
            axi.bvalid  <= 0; axi.bresp   <= 0;
            axi.rvalid  <= 0; axi.rdata   <= 0; axi.rresp <= 0; axi.rlast <= 0;
            s_st <= 0; s_wait <= 0; r_beat <= 0;
        end else begin
            case (s_st)
                0: begin
                    if (axi.awvalid && axi.awready) begin
                        cap_id <= axi.awid; cap_addr <= axi.awaddr; cap_len <= axi.awlen;
                        cap_size <= axi.awsize; cap_burst <= axi.awburst;
                        w_idx <= axi.awaddr[11:2];
                        axi.awready <= 0; axi.wready <= 1; s_wait <= 0; s_st <= 1;
                    end else if (axi.arvalid && axi.arready) begin
                        cap_id <= axi.arid; cap_addr <= axi.araddr; cap_len <= axi.arlen;
                        cap_size <= axi.arsize; cap_burst <= axi.arburst;
                        r_idx <= axi.araddr[11:2]; r_beat <= 0;
                        axi.arready <= 0; s_wait <= 0; s_st <= 3;
                        axi.rvalid <= 1;
                        axi.rdata  <= mem[axi.araddr[11:2]];
                        axi.rlast  <= (axi.arlen == 8'd0);
                        axi.rresp  <= (cfg_err_beat == 0) ? RESP_SLVERR : RESP_OKAY;
                    end else if (axi.awvalid || axi.arvalid) begin
                        if (s_wait >= cfg_aw_delay) begin
                            axi.awready <= axi.awvalid;
                            axi.arready <= axi.arvalid;
                        end else begin
                            s_wait <= s_wait + 1;
                        end
                    end
                end
                1: if (axi.wvalid && axi.wready) begin
                    if (wq.size() == 0) begin
                        check("w_unexpected_beat", 1, 0);
                    end else begin
                        e = wq.pop_front();
                        check("w_data", axi.wdata, e.data);
                        check("w_strb", axi.wstrb, e.strb);
                        check("w_last", axi.wlast, e.last);
                    end
                    for (int b = 0; b < 4; b++)
                        if (axi.wstrb[b]) mem[w_idx][8*b +: 8] <= axi.wdata[8*b +: 8];
                    w_idx <= w_idx + 10'd1;
                    if (axi.wlast) begin
                        axi.wready <= 0; axi.bvalid <= 1; axi.bresp <= cfg_bresp; s_st <= 2;
                    end
                end
                2: if (axi.bready) begin
                    axi.bvalid <= 0; axi.bresp <= 0; s_st <= 0;
                end
                3: if (axi.rready) begin
                    if (axi.rlast) begin
                        axi.rvalid <= 0; axi.rlast <= 0; axi.rdata <= 0; axi.rresp <= 0; s_st <= 0;
                    end else begin
                        nb = r_beat + 1;
                        r_beat <= nb;
                        axi.rdata <= mem[r_idx + 10'(nb)];
                        axi.rlast <= (nb == int'(cap_len));
                        axi.rresp <= (nb == cfg_err_beat) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                default: s_st <= 0;
            endcase
        end
    end

    // Mid-cycle monitor: address-channel stability, W gating, read beat scoreboard.
    logic        aw_pend, ar_pend;
    logic [32:0] aw_snap, ar_snap;

    always @(negedge clk) begin : monitor
        logic [32:0] e;
        if (rst) begin
            aw_pend <= 0; ar_pend <= 0;
        end else begin
            if (aw_pend) begin
                check("awvalid_held", axi.awvalid, 1);
                check("aw_payload_held", {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst}, aw_snap);
            end
            if (ar_pend) begin
                check("arvalid_held", axi.arvalid, 1);
                check("ar_payload_held", {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst}, ar_snap);
            end
            aw_pend <= axi.awvalid && !axi.awready;
            ar_pend <= axi.arvalid && !axi.arready;
            aw_snap <= {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst};
            ar_snap <= {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst};
            if (axi.awvalid) check("no_w_before_aw", axi.wvalid, 0);
            if (rd_valid && rd_ready) begin
                if (rq.size() == 0) begin
                    check("rd_unexpected_beat", 1, 0);
                end else begin
                    e = rq.pop_front();
                    check("rd_data", rd_data, e[31:0]);
                    check("rd_last", rd_last, e[32]);
                end
            end
        end
    end

    function automatic vec_t mk(input logic wr, input logic [3:0] id, input logic [15:0] addr,
                                input logic [7:0] len, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3, input logic [15:0] strb,
                                input int aw_delay, input logic bp, input logic [1:0] bresp,
                                input int err_beat, input logic [1:0] exp_resp);
        vec_t v;
        v.wr = wr; v.id = id; v.addr = addr; v.len = len;
        v.data = {d3, d2, d1, d0};
        v.strb = strb;
        v.aw_delay = aw_delay; v.bp = bp; v.bresp = bresp;
        v.err_beat = err_beat; v.exp_resp = exp_resp;
        return v;
    endfunction

    task automatic issue_req(input vec_t v);
        logic ok;
        cfg_aw_delay = v.aw_delay;
        cfg_bresp    = v.bresp;
        cfg_err_beat = v.err_beat;
        req_valid = 1; req_write = v.wr; req_id = v.id; req_addr = v.addr; req_len = v.len;
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            ok = req_ready;
            @(posedge clk); #1;
            if (ok) break;
        end
        req_valid = 0;
        check("req_accepted", ok, 1);
        check("addr_valid_after_accept", v.wr ? axi.awvalid : axi.arvalid, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int    beat, ph;
        logic  hs, pushed, tog, got;
        wexp_t e;
        issue_req(v);
        got = 0;
        if (v.wr) begin
            beat = 0; pushed = 0; tog = 1;
            for (int c = 0; c < 200 && beat <= int'(v.len); c++) begin
                wr_valid = v.bp ? tog : 1'b1;
                tog = !tog;
                wr_data = v.data[beat];
                wr_strb = v.strb[beat];
                if (wr_valid && !pushed) begin
                    e.last = (beat == int'(v.len)); e.strb = v.strb[beat]; e.data = v.data[beat];
                    wq.push_back(e);
                    pushed = 1;
                end
                @(negedge clk);
                hs = wr_valid && wr_ready;
                @(posedge clk); #1;
                if (hs) begin beat++; pushed = 0; end
            end
            wr_valid = 0;
            for (int c = 0; c < 100; c++) begin
                if (done) begin got = 1; break; end
                @(posedge clk); #1;
            end
        end else begin
            for (int b = 0; b <= int'(v.len); b++) rq.push_back({(b == int'(v.len)), v.data[b]});
            ph = 0;
            for (int c = 0; c < 300; c++) begin
                rd_ready = !v.bp || (ph >= 3);
                @(negedge clk);
                hs = rd_valid && rd_ready;
                @(posedge clk); #1;
                ph = hs ? 0 : ph + 1;
                if (done) begin got = 1; break; end
            end
            rd_ready = 0;
        end
        check("done_seen", got, 1);
        check("done_resp", done_resp, v.exp_resp);
        check("req_ready_in_done_cycle", req_ready, 1);
        check("ax_id", cap_id, v.id);
        check("ax_addr", cap_addr, v.addr);
        check("ax_len", cap_len, v.len);
        check("ax_size", cap_size, 3'd2);
        check("ax_burst", cap_burst, BURST_INCR);
        check("w_queue_drained", wq.size(), 0);
        check("rd_queue_drained", rq.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_awvalid"}, axi.awvalid, 0);
        check({tag, "_arvalid"}, axi.arvalid, 0);
        check({tag, "_wvalid"}, axi.wvalid, 0);
        check({tag, "_wdata"}, axi.wdata, 0);
        check({tag, "_bready"}, axi.bready, 0);
        check({tag, "_rready"}, axi.rready, 0);
        check({tag, "_wr_ready"}, wr_ready, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_done_resp"}, done_resp, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin : stimulus
        vec_t  vecs[6];
        vec_t  v;
        wexp_t e;
        logic  hs;

        vecs[0] = mk(1, 4'h1, 16'h0001, 8'd2, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF, 32'h0,
                     16'h09FF, 0, 0, RESP_OKAY, -1, RESP_OKAY);
        vecs[1] = mk(0, 4'h1, 16'h0001, 8'd2, 32'h01234567, 32'h89ABCDEF, 32'hFF0000FF, 32'h0,
                     16'h0000, 0, 0, RESP_OKAY, -1, RESP_OKAY);
        vecs[2] = mk(1, 4'h2, 16'h0040, 8'd0, 32'hA5A5A5A5, 32'h0, 32'h0, 32'h0,
                     16'h0003, 5, 0, RESP_OKAY, -1, RESP_OKAY);
        vecs[3] = mk(1, 4'h3, 16'h0044, 8'd1, 32'h11112222, 32'h33334444, 32'h0, 32'h0,
                     16'h00CF, 1, 1, RESP_DECERR, -1, RESP_DECERR);
        vecs[4] = mk(0, 4'h2, 16'h0040, 8'd3, 32'h0000A5A5, 32'h11112222, 32'h33330000, 32'h00000000,
                     16'h0000, 0, 1, RESP_OKAY, 1, RESP_SLVERR);
        vecs[5] = mk(0, 4'hF, 16'h0008, 8'd0, 32'hFF0000FF, 32'h0, 32'h0, 32'h0,
                     16'h0000, 2, 0, RESP_OKAY, -1, RESP_OKAY);

        req_valid = 0; req_write = 0; req_id = 0; req_addr = 0; req_len = 0;
        wr_valid = 0; wr_data = 0; wr_strb = 0; rd_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset during beat 2 of a 4-beat write.
        v = mk(1, 4'h4, 16'h0080, 8'd3, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004,
               16'hFFFF, 0, 0, RESP_OKAY, -1, RESP_OKAY);
        issue_req(v);
        wr_valid = 1; wr_data = v.data[0]; wr_strb = 4'hF;
        e.last = 0; e.strb = 4'hF; e.data = v.data[0];
        wq.push_back(e);
        hs = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            hs = wr_valid && wr_ready;
            @(posedge clk); #1;
            if (hs) break;
        end
        check("mid_write_beat1_done", hs, 1);
        wr_data = v.data[1];
        e.data = v.data[1];
        wq.push_back(e);
        @(negedge clk);
        check("mid_write_beat2_valid", axi.wvalid, 1);
        #1 rst = 1;
        #1;
        check_idle_outputs("async_reset");
        wr_valid = 0;
        wq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        check("req_ready_after_release", req_ready, 1);

        v = mk(0, 4'h5, 16'h0040, 8'd0, 32'h0000A5A5, 32'h0, 32'h0, 32'h0,
               16'h0000, 0, 0, RESP_OKAY, -1, RESP_OKAY);
        run_vec(v);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
